// File: rtl/pairing_io_pkg.sv
// Shared definitions for the pairing-core I/O blocks: core input-mode codes,
// result-word ordering and the result unloader FSM state type.
// Optional feature macro used by the users of this package:
// RESULT_UNLOAD_CHECKSUM_EN.
package pairing_io_pkg;

    // Core-facing field widths.
    localparam int WORD_SIZE        = 64;
    localparam int RAM_ADDR_SIZE    = 8;
    localparam int I_INPUTMODE_SIZE = 3;

    // Result bus geometry. The stream index is 5 bits so it can also
    // carry the checksum beat index.
    localparam int NUM_WORDS = 24;
    localparam int IDX_W     = 5;

    // Core input-mode codes. INPUT_COORD_CORE is the core's normal mode.
    localparam logic [I_INPUTMODE_SIZE-1:0] INPUT_COORD_CORE = 3'd0;
    localparam logic [I_INPUTMODE_SIZE-1:0] REF_RESULT       = 3'd3;

    // Typical RAM readback address.
    localparam logic [RAM_ADDR_SIZE-1:0] RAM_P_BT_0 = 8'h40;

    // Result names are resultABCD with A in 0..1, B in 0..2, C and D in 0..1.
    // result0000 is word 0, result1211 is word 23.
    function automatic int unsigned res_index(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        return ((a * 3 + b) * 2 + c) * 2 + d;
    endfunction

    localparam int RES_0000 = 0;
    localparam int RES_1211 = 23;

    // Result unloader sequencing.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_BUSY,
        ST_LATENCY,
        ST_STREAM
    } unload_state_t;

endpackage

// File: rtl/result_unloader_if.sv
// Host-side handshakes of the result unloader: the readback request channel
// and the valid/ready word stream. The unloader is the slave, the host the master.
// The checksum beat (RESULT_UNLOAD_CHECKSUM_EN) needs no extra signals here.
interface result_unloader_if #(
    parameter int WORD_W = 64,
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_raddr;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic [4:0]        out_idx;
    logic              out_last;

    modport slave (
        input  req_valid, req_raddr, out_ready,
        output req_ready, out_valid, out_data, out_idx, out_last
    );

    modport master (
        output req_valid, req_raddr, out_ready,
        input  req_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/result_capture_buf.sv
// Snapshot buffer for the core's result bus: loads all words in one edge,
// reads one word by index. With RESULT_UNLOAD_CHECKSUM_EN defined it also
// provides the XOR of all captured words.
module result_capture_buf
    import pairing_io_pkg::*;
#(
    parameter int WORD_W = WORD_SIZE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_load,
    input  logic [NUM_WORDS*WORD_W-1:0] i_bus,
    input  logic [IDX_W-1:0]            i_idx,
    output logic [WORD_W-1:0]           o_word
`ifdef RESULT_UNLOAD_CHECKSUM_EN
    ,
    output logic [WORD_W-1:0]           o_xor
`endif
);

    logic [WORD_W-1:0] r_buf [NUM_WORDS];

    // Parallel load of every word from the flattened bus; cleared on reset.
    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    // NOTE: this array is reset on purpose: a cleared buffer is visible state after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WORDS; i++) r_buf[i] <= '0;
        end else if (i_load) begin
            for (int i = 0; i < NUM_WORDS; i++) r_buf[i] <= i_bus[i*WORD_W +: WORD_W];
        end
    end

    // Read mux; out-of-range indices (the checksum beat) read as zero.
    // NOTE: default assignment first so no path leaves o_word unassigned (no latch).
    always_comb begin
        o_word = '0;
        if (i_idx < IDX_W'(NUM_WORDS)) o_word = r_buf[i_idx];
    end

`ifdef RESULT_UNLOAD_CHECKSUM_EN
    // XOR-reduce of the captured words for the checksum beat.
    always_comb begin
        o_xor = '0;
        for (int i = 0; i < NUM_WORDS; i++) o_xor = o_xor ^ r_buf[i];
    end
`endif

endmodule

// File: rtl/result_unloader.sv
// Result unloader: on request, points the core at a RAM address in REF_RESULT
// mode, waits the read latency, snapshots the 24-word result bus and streams
// it to the host one word per beat.
// RESULT_UNLOAD_CHECKSUM_EN adds a final XOR checksum beat at index 24.
module result_unloader
    import pairing_io_pkg::*;
#(
    parameter int WORD_W = WORD_SIZE,
    parameter int ADDR_W = RAM_ADDR_SIZE,
    parameter int MODE_W = I_INPUTMODE_SIZE,
    parameter int RD_LAT = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    result_unloader_if.slave            host,
    input  logic                        core_busy,
    output logic [MODE_W-1:0]           o_inputmode,
    output logic [ADDR_W-1:0]           o_raddr,
    output logic                        o_mode_own,
    input  logic [NUM_WORDS*WORD_W-1:0] res_bus
);

`ifdef RESULT_UNLOAD_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
`endif
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    unload_state_t     r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_req_ready;
    logic              r_out_valid;
    logic              r_out_last;
    logic              r_mode_own;
    logic [MODE_W-1:0] r_inputmode;
    logic [ADDR_W-1:0] r_raddr;

    logic              w_load;
    logic              w_beat;
    logic [WORD_W-1:0] w_buf_word;
    logic [WORD_W-1:0] w_out_data;
`ifdef RESULT_UNLOAD_CHECKSUM_EN
    logic [WORD_W-1:0] w_xor;
`endif

    // The bus is snapshotted on the last latency edge.
    assign w_load = (r_state == ST_LATENCY) && (r_cnt == '0);
    assign w_beat = r_out_valid && host.out_ready;

    result_capture_buf #(.WORD_W(WORD_W)) u_buf (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_bus  (res_bus),
        .i_idx  (r_idx),
        .o_word (w_buf_word)
`ifdef RESULT_UNLOAD_CHECKSUM_EN
        ,
        .o_xor  (w_xor)
`endif
    );

    // Stream data: buffered word, or the checksum on the extra beat; zero when idle.
    always_comb begin
        w_out_data = '0;
        if (r_out_valid) begin
            w_out_data = w_buf_word;
`ifdef RESULT_UNLOAD_CHECKSUM_EN
            if (r_idx == IDX_W'(NUM_WORDS)) w_out_data = w_xor;
`endif
        end
    end

    // Readback sequencer with registered handshake and core-control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_req_ready <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_mode_own  <= 1'b0;
            r_inputmode <= '0;
            r_raddr     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (host.req_valid && r_req_ready) begin
                        r_raddr     <= host.req_raddr;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (!core_busy) begin
                        r_inputmode <= MODE_W'(REF_RESULT);
                        r_mode_own  <= 1'b1;
                        r_cnt       <= CNT_W'(RD_LAT - 1);
                        r_state     <= ST_LATENCY;
                    end
                end
                ST_LATENCY: begin
                    // core_busy is deliberately not looked at: the core holds
                    // its readout stable once the read has started.
                    if (r_cnt == '0) begin
                        r_mode_own  <= 1'b0;
                        r_inputmode <= MODE_W'(INPUT_COORD_CORE);
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_state     <= ST_STREAM;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (w_beat) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_idx       <= '0;
                            r_req_ready <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_idx      <= r_idx + 1'b1;
                            r_out_last <= ((r_idx + 1'b1) == LAST_IDX);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign host.req_ready = r_req_ready;
    assign host.out_valid = r_out_valid;
    assign host.out_data  = w_out_data;
    assign host.out_idx   = r_idx;
    assign host.out_last  = r_out_last;
    assign o_inputmode    = r_inputmode;
    assign o_raddr        = r_raddr;
    assign o_mode_own     = r_mode_own;

endmodule

// File: tb/tb_result_unloader.sv
// Self-checking bench for result_unloader: randomized transactions compared
// against a word-array model of the expected stream. Honours
// RESULT_UNLOAD_CHECKSUM_EN when it is defined for the build.
module tb_result_unloader;
    import pairing_io_pkg::*;

    localparam int WORD_W = 64;
    localparam int ADDR_W = 8;
    localparam int MODE_W = 3;
    localparam int RD_LAT = 3;
`ifdef RESULT_UNLOAD_CHECKSUM_EN
    localparam int NBEATS = NUM_WORDS + 1;
`else
    localparam int NBEATS = NUM_WORDS;
`endif

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        core_busy = 1'b0;
    logic [NUM_WORDS*WORD_W-1:0] res_bus = '0;
    logic [MODE_W-1:0]           o_inputmode;
    logic [ADDR_W-1:0]           o_raddr;
    logic                        o_mode_own;

    result_unloader_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) host_if ();

    result_unloader #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W),
        .MODE_W (MODE_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .host        (host_if.slave),
        .core_busy   (core_busy),
        .o_inputmode (o_inputmode),
        .o_raddr     (o_raddr),
        .o_mode_own  (o_mode_own),
        .res_bus     (res_bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: the words the host should receive, as placed on the bus before the request.
    logic [WORD_W-1:0] exp_words [NUM_WORDS];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WORD_W-1:0] model_beat(input int idx);
        logic [WORD_W-1:0] x;
        if (idx < NUM_WORDS) return exp_words[idx];
        x = '0;
        foreach (exp_words[i]) x ^= exp_words[i];
        return x;
    endfunction

    task automatic load_bus();
        for (int k = 0; k < NUM_WORDS; k++) res_bus[k*WORD_W +: WORD_W] = exp_words[k];
    endtask

    task automatic fill_incr();
        for (int k = 0; k < NUM_WORDS; k++) exp_words[k] = 64'h1000 + 64'(k);
    endtask

    task automatic fill_rand();
        for (int k = 0; k < NUM_WORDS; k++) exp_words[k] = {$urandom, $urandom};
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req_ready"}, host_if.req_ready, 1);
        check({tag, "_out_valid"}, host_if.out_valid, 0);
        check({tag, "_out_last"},  host_if.out_last, 0);
        check({tag, "_out_idx"},   host_if.out_idx, 0);
        check({tag, "_out_data"},  host_if.out_data, 0);
        check({tag, "_mode_own"},  o_mode_own, 0);
        check({tag, "_inputmode"}, o_inputmode, 0);
        check({tag, "_raddr"},     o_raddr, 0);
    endtask

    // One readback. busy_cyc: cycles core_busy stays high after the request.
    // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    // rst_at >= 0 asserts reset when that beat index is on the bus.
    task automatic run_txn(input logic [ADDR_W-1:0] addr, input int busy_cyc, input int ready_mode,
                           input bit corrupt, input bit spam, input int rst_at);
        int idx;
        int cyc;
        bit rdy;
        bit own;
        load_bus();
        @(negedge clk);
        check("req_ready_idle", host_if.req_ready, 1);
        host_if.req_valid = 1'b1;
        host_if.req_raddr = addr;
        // Request, busy wait and latency: first valid RD_LAT+1 cycles after busy is seen low.
        for (int k = 1; k <= busy_cyc + RD_LAT + 2; k++) begin
            @(negedge clk);
            if (k == 1) begin
                host_if.req_valid = 1'b0;
                check("raddr_latched", o_raddr, addr);
            end
            own = (k >= busy_cyc + 2) && (k <= busy_cyc + RD_LAT + 1);
            check("req_ready_busy", host_if.req_ready, 0);
            check("out_valid_timing", host_if.out_valid, (k == busy_cyc + RD_LAT + 2));
            check("mode_own", o_mode_own, own);
            check("inputmode", o_inputmode, own ? REF_RESULT : INPUT_COORD_CORE);
            if (k <= busy_cyc)          core_busy = 1'b1;
            else if (k == busy_cyc + 1) core_busy = 1'b0;
            else                        core_busy = 1'($urandom_range(0, 1));
        end
        core_busy = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < NBEATS && cyc < 400) begin
            if (cyc > 0) @(negedge clk);
            check("out_valid", host_if.out_valid, 1);
            check("out_idx", host_if.out_idx, idx);
            check("out_data", host_if.out_data, model_beat(idx));
            check("out_last", host_if.out_last, (idx == NBEATS - 1));
            check("stream_mode_own", o_mode_own, 0);
            check("raddr_hold", o_raddr, addr);
            if (idx == rst_at) begin
                rst = 1'b1;
                host_if.out_ready = 1'b0;
                host_if.req_valid = 1'b0;
                @(negedge clk);
                check_reset_state("midrst");
                rst = 1'b0;
                return;
            end
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            host_if.out_ready = rdy;
            if (corrupt && cyc == 3) res_bus = '1;
            if (spam) begin
                host_if.req_valid = 1'b1;
                host_if.req_raddr = ~addr;
            end
            if (rdy) idx++;
            cyc++;
        end
        if (idx < NBEATS) check("stream_timeout", 64'(idx), 64'(NBEATS));
        @(negedge clk);
        host_if.req_valid = 1'b0;
        host_if.out_ready = 1'b0;
        check("done_out_valid", host_if.out_valid, 0);
        check("done_req_ready", host_if.req_ready, 1);
        check("done_out_idx", host_if.out_idx, 0);
        check("done_out_last", host_if.out_last, 0);
        check("done_raddr", o_raddr, addr);
        if (spam) begin
            repeat (3) begin
                @(negedge clk);
                check("no_second_xfer", host_if.out_valid, 0);
                check("idle_req_ready", host_if.req_ready, 1);
            end
        end
    endtask

    initial begin
        host_if.req_valid = 1'b0;
        host_if.req_raddr = '0;
        host_if.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // Basic readback with incrementing words.
        fill_incr();
        run_txn(RAM_P_BT_0, 0, 0, 1'b0, 1'b0, -1);
`ifdef RESULT_UNLOAD_CHECKSUM_EN
        check("checksum_incr", model_beat(NUM_WORDS), 64'h0);
`endif
        // Busy stall of 10 cycles.
        fill_rand();
        run_txn(8'h11, 10, 0, 1'b0, 1'b0, -1);
        // Backpressure 1,0,0,1 with the bus overwritten mid-stream.
        fill_rand();
        run_txn(8'h22, 2, 1, 1'b1, 1'b0, -1);
        // Reset at beat 10, then a full transfer.
        fill_rand();
        run_txn(8'h33, 1, 0, 1'b0, 1'b0, 10);
        fill_rand();
        run_txn(8'h44, 0, 2, 1'b0, 1'b0, -1);
        // Request held during the stream with another address.
        fill_rand();
        run_txn(8'h55, 0, 1, 1'b0, 1'b1, -1);
        // Randomized mix.
        for (int t = 0; t < 8; t++) begin
            fill_rand();
            run_txn(8'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
